// File: rtl/valid_gen_pkg.sv
// Shared definitions for the valid_gen pulse generator: FSM state encoding
// and the default period constants for each i_sel setting.
package valid_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default periods in clocks, one per i_sel value.
    localparam longint unsigned DEF_LIMIT_0 = 64'd1 << 23;
    localparam longint unsigned DEF_LIMIT_1 = 64'd1 << 24;
    localparam longint unsigned DEF_LIMIT_2 = 64'd1 << 25;
    localparam longint unsigned DEF_LIMIT_3 = 64'd1 << 26;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for slow asynchronous switch inputs. Each bit is
// synchronized independently; the bus is assumed to change slowly enough
// that a one-cycle skew between bits is harmless.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Shift the raw input through two stages to resolve metastability.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= i_d;
            sync_reg <= meta_reg;
        end
    end

    assign o_q = sync_reg;

endmodule

// File: rtl/valid_gen.sv
// Periodic single-cycle valid pulse generator. While enabled, emits o_valid
// once every LIMIT_<sel> clocks and counts the pulses; a change of period
// selection restarts the current period.
module valid_gen
    import valid_gen_pkg::*;
#(
    parameter int              NB_COUNTER = 32,
    parameter longint unsigned LIMIT_0    = DEF_LIMIT_0,
    parameter longint unsigned LIMIT_1    = DEF_LIMIT_1,
    parameter longint unsigned LIMIT_2    = DEF_LIMIT_2,
    parameter longint unsigned LIMIT_3    = DEF_LIMIT_3,
    parameter int              NB_PULSES  = 8
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [1:0]           i_sel,
    output logic                 o_valid,
    output logic [NB_PULSES-1:0] o_pulse_cnt,
    output logic                 o_running
);

    // Terminal counter value for each period; LIMIT of 2**NB_COUNTER wraps
    // correctly to all-ones here.
    localparam logic [NB_COUNTER-1:0] LAST_0 = NB_COUNTER'(LIMIT_0 - 64'd1);
    localparam logic [NB_COUNTER-1:0] LAST_1 = NB_COUNTER'(LIMIT_1 - 64'd1);
    localparam logic [NB_COUNTER-1:0] LAST_2 = NB_COUNTER'(LIMIT_2 - 64'd1);
    localparam logic [NB_COUNTER-1:0] LAST_3 = NB_COUNTER'(LIMIT_3 - 64'd1);

    logic [2:0]            sync_out;
    logic                  en_s;
    logic [1:0]            sel_s;
    logic [1:0]            sel_prev_reg;
    logic [NB_COUNTER-1:0] last_sel;

    state_t                state_reg;
    logic [NB_COUNTER-1:0] counter_reg;
    logic                  valid_reg;
    logic [NB_PULSES-1:0]  pulse_cnt_reg;
    logic                  running_reg;

    sync2 #(
        .WIDTH (3)
    ) u_sync (
        .clock   (clock),
        .i_reset (i_reset),
        .i_d     ({i_enable, i_sel}),
        .o_q     (sync_out)
    );

    assign en_s  = sync_out[2];
    assign sel_s = sync_out[1:0];

    // Pick the terminal count for the currently selected period.
    always_comb begin
        case (sel_s)
            2'd0:    last_sel = LAST_0;
            2'd1:    last_sel = LAST_1;
            2'd2:    last_sel = LAST_2;
            default: last_sel = LAST_3;
        endcase
    end

    // Remember last cycle's selection so a period change can be detected.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            sel_prev_reg <= 2'd0;
        end else begin
            sel_prev_reg <= sel_s;
        end
    end

    // Main FSM: period counting, pulse emission and pulse counting.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg     <= IDLE;
            counter_reg   <= '0;
            valid_reg     <= 1'b0;
            pulse_cnt_reg <= '0;
            running_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    counter_reg   <= '0;
                    valid_reg     <= 1'b0;
                    pulse_cnt_reg <= '0;
                    if (en_s) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                    end else begin
                        running_reg <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en_s) begin
                        // Disable wins even on the terminal count: no pulse.
                        state_reg     <= IDLE;
                        counter_reg   <= '0;
                        valid_reg     <= 1'b0;
                        pulse_cnt_reg <= '0;
                        running_reg   <= 1'b0;
                    end else if (sel_s != sel_prev_reg) begin
                        // New period selected: drop the partial period.
                        counter_reg <= '0;
                        valid_reg   <= 1'b0;
                    end else if (counter_reg == last_sel) begin
                        counter_reg   <= '0;
                        valid_reg     <= 1'b1;
                        pulse_cnt_reg <= pulse_cnt_reg + NB_PULSES'(1);
                    end else begin
                        counter_reg <= counter_reg + NB_COUNTER'(1);
                        valid_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    counter_reg   <= '0;
                    valid_reg     <= 1'b0;
                    pulse_cnt_reg <= '0;
                    running_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid     = valid_reg;
    assign o_pulse_cnt = pulse_cnt_reg;
    assign o_running   = running_reg;

endmodule

// File: doc/valid_gen.md
VALID_GEN -- requirements
Module: valid_gen

Interface
REQ-001 Parameter NB_COUNTER, default 32: width of the internal period counter.
REQ-002 Parameter LIMIT_0, default 2**23: period in clocks for i_sel = 0.
REQ-003 Parameter LIMIT_1, default 2**24: period in clocks for i_sel = 1.
REQ-004 Parameter LIMIT_2, default 2**25: period in clocks for i_sel = 2.
REQ-005 Parameter LIMIT_3, default 2**26: period in clocks for i_sel = 3.
REQ-006 Parameter NB_PULSES, default 8: width of the emitted-pulse counter.
REQ-007 clock  input  1  single system clock; all state updates on its rising edge.
REQ-008 i_reset  input  1  asynchronous, active-high reset.
REQ-009 i_enable  input  1  asynchronous switch input; high = generate pulses.
REQ-010 i_sel  input  2  asynchronous switch input; selects period LIMIT_<i_sel>.
REQ-011 o_valid  output  1  registered single-cycle enable pulse for the downstream LED-toggle block.
REQ-012 o_pulse_cnt  output  NB_PULSES  registered count of pulses emitted since leaving IDLE, wraps modulo 2**NB_PULSES.
REQ-013 o_running  output  1  registered, high while in state RUN.

Function
REQ-014 i_enable and i_sel SHALL each pass through a 2-flop synchronizer; "en_s"/"sel_s" denote synchronized values, 2-cycle latency from the input pin.
REQ-015 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-016 IDLE -> RUN when en_s = 1; RUN -> IDLE when en_s = 0; transitions take effect on the next rising edge.
REQ-017 In IDLE: counter = 0, o_valid = 0, o_pulse_cnt = 0, o_running = 0.
REQ-018 In RUN the counter SHALL increment by 1 per clock starting from 0 on the first RUN cycle.
REQ-019 In RUN, at an edge where counter = L-1 (L = selected limit), counter <= 0, o_valid <= 1, o_pulse_cnt <= o_pulse_cnt + 1; at all other edges o_valid <= 0.
REQ-020 Consequently o_valid SHALL be high for exactly one cycle every L cycles, first pulse L cycles after the first RUN cycle.
REQ-021 A change of sel_s relative to its previous-cycle value while in RUN SHALL force counter <= 0 and o_valid <= 0 that edge, without changing state or o_pulse_cnt; the new period applies from that point.
REQ-022 en_s falling while counter = L-1 SHALL take priority: no pulse is emitted, state -> IDLE.
REQ-023 o_pulse_cnt SHALL wrap from 2**NB_PULSES-1 to 0 without side effects.
REQ-024 Comparison SHALL be done at NB_COUNTER width; LIMIT_x SHALL be >= 2 and <= 2**NB_COUNTER; values outside this range are illegal configuration.

Reset
REQ-025 i_reset high SHALL immediately (without a clock edge) force state IDLE, counter 0, o_valid 0, o_pulse_cnt 0, o_running 0, and all synchronizer and previous-sel flops 0.
REQ-026 Reset asserted mid-period SHALL discard the partial period; after release, behaviour resumes per REQ-016 with the counter starting from 0.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE, RUN) and the default LIMIT_x constants.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module, sync2, parameterized on width and instantiated once for {i_enable, i_sel}.
REQ-029 All outputs SHALL be driven directly from flops; no combinational input-to-output path.

Verification (bench overrides LIMIT_0..3 = 4, 8, 16, 32)
REQ-030 i_sel=0, i_enable 0->1 -> o_running high 3 cycles later, o_valid pulses every 4 cycles, o_pulse_cnt 1,2,3,...
REQ-031 i_sel 0->3 mid-period in RUN -> no pulse for that period; next pulse 32 cycles after the sel_s change is seen.
REQ-032 i_enable dropped timed so that en_s falls at the edge where counter = 3 (i_sel=0) -> no pulse, o_running 0, o_pulse_cnt 0.
REQ-033 i_reset pulsed asynchronously between edges mid-period -> all outputs 0 before the next edge; after release, first pulse 4 cycles after re-entering RUN.
REQ-034 NB_PULSES=2, 5 pulses at i_sel=1 -> o_pulse_cnt sequence 1,2,3,0,1, o_valid period 8 throughout.
REQ-035 i_enable held 0 for 100 cycles -> o_valid, o_running and o_pulse_cnt remain 0.
